uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
Serialises one parallel word per request onto the UART tx line: start bit, D_BITS data bits LSB-first, then stop bit(s).
Bit timing comes from an external oversampling tick, s_tick, at 16 ticks per bit period. This is the same tick source the UART receiver uses.
Sits between the user/FIFO side and the pad, as the transmit half of the UART core.

Parameters:
D_BITS, 8, data bits per frame (5..9)
SB_TICK, 16, s_tick count for the stop period: 16 = 1 stop bit, 24 = 1.5, 32 = 2. Legal values are 16, 24, 32 only.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
s_tick  input  1  oversampling enable, one clk cycle wide, 16 per bit period
tx_start  input  1  start request; sampled only in IDLE
tx_din  input  D_BITS  word to send; sampled in the cycle tx_start is accepted
tx  output  1  serial line, registered, idle high
tx_busy  output  1  high whenever state != IDLE
tx_done_tick  output  1  one-clk pulse at end of the stop period

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; tick counter s = 0; bit counter n = 0; shift register b = 0.
  - tx = 1 (driven high immediately on reset assertion, not on the next clock edge); tx_busy = 0; tx_done_tick = 0.
- Counter widths:
  - s is 5 bits, sized to hold SB_TICK-1 = 31.
  - n is $clog2(D_BITS) bits; D_BITS=8 gives 3 bits. No wrap is ever reached, because every compare terminates first.
- IDLE:
  - tx = 1.
  - On tx_start = 1: b <= tx_din, s <= 0, state <= START.
  - tx = 0 on the clk edge following acceptance. The first bit is not aligned to s_tick.
- START:
  - tx = 0.
  - On s_tick with s == 15: s <= 0, n <= 0, state <= DATA.
  - On s_tick with s != 15: s <= s+1.
  - Cycles without s_tick hold all registers.
- DATA:
  - tx = b[0].
  - On s_tick with s == 15: s <= 0 and b <= b >> 1.
  - If n == D_BITS-1 the next state is STOP (or PARITY, see Optional Feature); otherwise n <= n+1.
  - On s_tick with s != 15: s <= s+1.
- STOP:
  - tx = 1.
  - On s_tick with s == SB_TICK-1: tx_done_tick = 1 for that clk cycle, state <= IDLE.
  - On s_tick with s != SB_TICK-1: s <= s+1.
- tx_done_tick is a Mealy output. It is asserted in the same cycle as the terminating s_tick and is never asserted outside that cycle.
- tx is produced by a registered next-value (tx_next) so that no glitches reach the pad.
- Frame length is exactly (1 + D_BITS)*16 + SB_TICK s_ticks from the first tick after acceptance.
- tx_start while busy is ignored, with no queuing. tx_din changes after acceptance do not affect the frame.
- tx_start in the same cycle that tx_done_tick fires is ignored, because state is still STOP. It is accepted one cycle later if still held.
- s_tick and tx_start arriving together in IDLE: the request is accepted, and that tick is not counted.
- Reset mid-frame aborts the frame:
  - tx goes to 1 asynchronously; no tx_done_tick is produced.
  - The line shows a short low pulse, which the far end treats as a framing error. This is accepted.
- An illegal state encoding recovers to IDLE with tx = 1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP.
  - tx = even parity over the latched word, i.e. XOR of the D_BITS bits as captured at acceptance.
  - PARITY lasts 16 s_ticks (s 0..15); then s <= 0 and state <= STOP.
  - Frame length becomes (2 + D_BITS)*16 + SB_TICK ticks.
  - The parity value is computed from tx_din at acceptance and held in a 1-bit register, reset value 0.
- Undefined: no PARITY state or register; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - state localparams IDLE=0, START=1, DATA=2, STOP=3, PARITY=4, 3-bit encoding common with the receiver;
  - OVERSAMPLE = 16;
  - the legal SB_TICK constants SB_1 = 16, SB_1P5 = 24, SB_2 = 32.
- No sub-module: the baud/tick generator already exists and is shared, and the FSM, counters and shifter live in one module.

Test Plan:
1. D_BITS=8, SB_TICK=16, s_tick every 4 clk; tx_start with tx_din=0xA5:
   - tx reads 0, then 1,0,1,0,0,1,0,1, then 1, each held 64 clk;
   - tx_done_tick fires once, 160 ticks after acceptance;
   - tx_busy is high throughout the frame.
2. After reset, s_tick toggling, tx_start low for 1000 clk: tx stays 1, tx_busy = 0, tx_done_tick = 0.
3. Mid-frame tx_start pulses with tx_din=0xFF while sending 0x00: frame is all-zero data and 160 ticks long; only one tx_done_tick.
4. tx_start held high continuously with tx_din=0x3C:
   - back-to-back frames, each starting 1 clk after the previous tx_done_tick;
   - no lost or extra stop time.
5. Reset asserted during DATA bit 3:
   - tx = 1 and tx_busy = 0 within the same cycle, with no tx_done_tick;
   - the next request, 0x5A, transmits correctly.
6. SB_TICK=32 with UART_TX_PARITY_EN defined, tx_din=0x07:
   - parity bit = 1;
   - stop high for 32 ticks;
   - tx_done_tick fires 192 ticks after acceptance.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
// Holds the common 3-bit state encoding, the oversampling ratio and the
// legal stop-period tick counts.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;

  localparam int OVERSAMPLE = 16;

  localparam int SB_1   = 16;
  localparam int SB_1P5 = 24;
  localparam int SB_2   = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_STOP   = STOP,
    ST_PARITY = PARITY
  } state_e;

  // Map an SB_TICK value to the one actually used; anything other than
  // 1, 1.5 or 2 stop bits falls back to a single stop bit.
  function automatic int sb_legal(input int sb);
    return (sb == SB_1 || sb == SB_1P5 || sb == SB_2) ? sb : SB_1;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one D_BITS word per request as
// start bit, data LSB-first, optional even parity, then stop bit(s).
// Bit timing comes from the shared 16x oversampling tick s_tick.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop period.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int D_BITS  = 8,
  parameter int SB_TICK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              tx_start,
  input  logic [D_BITS-1:0] tx_din,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  localparam int              N_W         = (D_BITS > 1) ? $clog2(D_BITS) : 1;
  localparam logic [4:0]      S_BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]      S_STOP_LAST = 5'(sb_legal(SB_TICK) - 1);
  localparam logic [N_W-1:0]  N_LAST      = N_W'(D_BITS - 1);

  state_e            state_q, state_d;
  logic [4:0]        s_q, s_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [D_BITS-1:0] b_q, b_d;
  logic              tx_q, tx_d;
  logic              done_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Next-state, counter, shifter and Mealy done-pulse logic; tx_d is the
  // line level belonging to the next state so the pad sees a clean flop.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          b_d     = tx_din;
          s_d     = 5'd0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_din;
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = 5'd0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = 5'd0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = 5'd0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        // Illegal encoding: fall back to an idle, high line.
        state_d = ST_IDLE;
        s_d     = 5'd0;
      end
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset forces the line high immediately and aborts any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= 5'd0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done_d;

endmodule
